// File: rtl/hd_timing_gen_if.sv
// rtl/hd_timing_gen_if.sv - HD raster timing bundle between the timing generator and its consumers
//
// Signals:
//   i_frame_end  consumer -> generator  one-cycle PAL frame-end pulse (genlock request)
//   o_hd_clk     generator -> consumer  pixel strobe, falling edge marks a pixel
//   o_pix_en     generator -> consumer  one-cycle pulse per pixel
//   o_hd_hsync   generator -> consumer  active-high horizontal sync
//   o_hd_vsync   generator -> consumer  active-high vertical sync
//   o_hd_de      generator -> consumer  data enable, high in the active region
//   o_h_count    generator -> consumer  pixel index (12 bits)
//   o_v_count    generator -> consumer  line index (11 bits)
//   o_locked     generator -> consumer  genlock status
// master: the timing generator. slave: the upsampler / output stage.
interface hd_timing_gen_if;
  logic        i_frame_end;
  logic        o_hd_clk;
  logic        o_pix_en;
  logic        o_hd_hsync;
  logic        o_hd_vsync;
  logic        o_hd_de;
  logic [11:0] o_h_count;
  logic [10:0] o_v_count;
  logic        o_locked;

  modport master (
    input  i_frame_end,
    output o_hd_clk, o_pix_en, o_hd_hsync, o_hd_vsync, o_hd_de,
    output o_h_count, o_v_count, o_locked
  );

  modport slave (
    output i_frame_end,
    input  o_hd_clk, o_pix_en, o_hd_hsync, o_hd_vsync, o_hd_de,
    input  o_h_count, o_v_count, o_locked
  );
endinterface

// File: rtl/hd_timing_gen.sv
// rtl/hd_timing_gen.sv - free-running HD raster timing generator with optional PAL genlock
//
// Purpose: divides clk_out into a pixel strobe, runs horizontal/vertical raster
// counters and decodes sync and data-enable. When HD_GENLOCK_EN is defined, a
// frame-end pulse re-phases the vertical counter to LOCK_LINE at the next line
// step; otherwise i_frame_end is ignored and o_locked stays 0.
//
// Ports:
//   clk_out  in   system and video clock
//   reset    in   asynchronous active-high reset
//   bus      hd_timing_gen_if.master (i_frame_end in; pixel strobe, syncs,
//            data enable, counters and lock status out)
//
// Optional feature macro: HD_GENLOCK_EN
module hd_timing_gen #(
  parameter int PIX_DIV   = 2,
  parameter int H_ACT     = 1280,
  parameter int H_FP      = 440,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACT     = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int LOCK_LINE = 0
) (
  input logic             clk_out,
  input logic             reset,
  hd_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [4:0]  DIV_MAX  = 5'(PIX_DIV - 1);
  localparam logic [4:0]  DIV_HALF = 5'(PIX_DIV / 2);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT_W  = 12'(H_ACT);
  localparam logic [11:0] HS_START = 12'(H_ACT + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACT + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACT);
  localparam logic [10:0] VS_START = 11'(V_ACT + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACT + V_FP + V_SYNC);
  localparam logic [10:0] V_LOCK   = 11'(LOCK_LINE);

  logic [4:0]  div, div_nxt;
  logic        hd_clk, pix_en;
  logic [11:0] h, h_nxt;
  logic [10:0] v, v_nxt, v_inc;
  logic        hsync, vsync, de, locked;
  logic        line_step;
  logic        load;

  assign div_nxt   = (div == DIV_MAX) ? 5'd0 : div + 5'd1;
  // pix_en is registered from div_nxt, so it is high exactly while div == PIX_DIV/2.
  assign line_step = pix_en && (h == H_LAST);
  assign h_nxt     = !pix_en ? h : ((h == H_LAST) ? 12'd0 : h + 12'd1);
  assign v_inc     = (v == V_LAST) ? 11'd0 : v + 11'd1;
  assign v_nxt     = !line_step ? v : (load ? V_LOCK : v_inc);

`ifdef HD_GENLOCK_EN
  typedef enum logic {FREE, PEND} gl_state_t;
  gl_state_t state, state_nxt;

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) state <= FREE;
    else       state <= state_nxt;
  end

  // A pulse arriving on a line-step cycle only arms PEND; the load waits for
  // the following line step. Pulses seen while PEND are absorbed.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      FREE: if (bus.i_frame_end) state_nxt = PEND;
      PEND: if (line_step) begin
        load      = 1'b1;
        state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
  end
`else
  logic unused_frame_end;
  assign unused_frame_end = bus.i_frame_end;
  assign load = 1'b0;
`endif

  // Outputs are decoded from the next counter values so that syncs, DE and
  // the published counters all step together on the same edge.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      div    <= 5'd0;
      hd_clk <= 1'b1;
      pix_en <= 1'b0;
      h      <= 12'd0;
      v      <= 11'd0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      de     <= 1'b1;
      locked <= 1'b0;
    end else begin
      div    <= div_nxt;
      hd_clk <= (div_nxt < DIV_HALF);
      pix_en <= (div_nxt == DIV_HALF);
      h      <= h_nxt;
      v      <= v_nxt;
      hsync  <= (h_nxt >= HS_START) && (h_nxt < HS_END);
      vsync  <= (v_nxt >= VS_START) && (v_nxt < VS_END);
      de     <= (h_nxt < H_ACT_W) && (v_nxt < V_ACT_W);
      if (load) locked <= (v_inc == V_LOCK);
    end
  end

  assign bus.o_hd_clk   = hd_clk;
  assign bus.o_pix_en   = pix_en;
  assign bus.o_hd_hsync = hsync;
  assign bus.o_hd_vsync = vsync;
  assign bus.o_hd_de    = de;
  assign bus.o_h_count  = h;
  assign bus.o_v_count  = v;
  assign bus.o_locked   = locked;

endmodule

// File: tb/tb_hd_timing_gen.sv
// tb/tb_hd_timing_gen.sv - directed self-checking bench for hd_timing_gen
module tb_hd_timing_gen;

  logic clk_out = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

`ifdef HD_GENLOCK_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  always #5 clk_out = ~clk_out;

  hd_timing_gen_if bus ();

  hd_timing_gen #(
    .PIX_DIV(2), .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .LOCK_LINE(2)
  ) dut (
    .clk_out (clk_out),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hd_clk"}, 32'(bus.o_hd_clk), 1);
    check({tag, "_pix_en"}, 32'(bus.o_pix_en), 0);
    check({tag, "_hsync"},  32'(bus.o_hd_hsync), 0);
    check({tag, "_vsync"},  32'(bus.o_hd_vsync), 0);
    check({tag, "_de"},     32'(bus.o_hd_de), 1);
    check({tag, "_h"},      32'(bus.o_h_count), 0);
    check({tag, "_v"},      32'(bus.o_v_count), 0);
    check({tag, "_locked"}, 32'(bus.o_locked), 0);
  endtask

  task automatic wait_hv(input int hh, input int vv);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 1000) begin
      @(negedge clk_out);
      n++;
      if (int'(bus.o_h_count) == hh && int'(bus.o_v_count) == vv) ok = 1'b1;
    end
    check("wait_hv_reached", 32'(ok), 1);
  endtask

  task automatic next_line();
    int n = 0;
    bit ok = 1'b0;
    while (bus.o_h_count == 12'd0 && n < 100) begin
      @(negedge clk_out);
      n++;
    end
    while (!ok && n < 1000) begin
      @(negedge clk_out);
      n++;
      if (bus.o_h_count == 12'd0) ok = 1'b1;
    end
    check("next_line_reached", 32'(ok), 1);
  endtask

  task automatic pulse_frame_end();
    bus.i_frame_end = 1'b1;
    @(negedge clk_out);
    bus.i_frame_end = 1'b0;
  endtask

  initial begin
    int h_e, v_e, hs_cnt, vs_cnt, de_cnt;
    bus.i_frame_end = 1'b0;

    // Reset state
    @(negedge clk_out);
    @(negedge clk_out);
    check_reset_vals("rst");

    // Free run for two frames against a closed-form raster model
    reset = 1'b0;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    for (int t = 1; t <= 392; t++) begin
      @(negedge clk_out);
      h_e = (t / 2) % 14;
      v_e = (t / 28) % 7;
      check("pix_en",  32'(bus.o_pix_en), 32'(t % 2 == 1));
      check("hd_clk",  32'(bus.o_hd_clk), 32'(t % 2 == 0));
      check("h_count", 32'(bus.o_h_count), 32'(h_e));
      check("v_count", 32'(bus.o_v_count), 32'(v_e));
      check("hsync",   32'(bus.o_hd_hsync), 32'(h_e >= 10 && h_e < 12));
      check("vsync",   32'(bus.o_hd_vsync), 32'(v_e == 5));
      check("de",      32'(bus.o_hd_de), 32'(h_e < 8 && v_e < 4));
      check("locked_free", 32'(bus.o_locked), 0);
      hs_cnt += int'(bus.o_hd_hsync);
      vs_cnt += int'(bus.o_hd_vsync);
      de_cnt += int'(bus.o_hd_de);
    end
    check("hsync_cycles_2frames", 32'(hs_cnt), 56);
    check("vsync_cycles_2frames", 32'(vs_cnt), 56);
    check("de_cycles_2frames",    32'(de_cnt), 128);

    // Genlock from v=4 mid-line: correction needed
    wait_hv(3, 4);
    pulse_frame_end();
    next_line();
    check("lock1_v",      32'(bus.o_v_count), GL ? 2 : 5);
    check("lock1_locked", 32'(bus.o_locked), 0);

    // Genlock from v=1: incremented value already equals LOCK_LINE
    wait_hv(4, 1);
    pulse_frame_end();
    next_line();
    check("lock2_v",      32'(bus.o_v_count), 2);
    check("lock2_locked", 32'(bus.o_locked), GL ? 1 : 0);

    // Two pulses within one line: exactly one load
    wait_hv(2, 3);
    pulse_frame_end();
    wait_hv(6, 3);
    pulse_frame_end();
    next_line();
    check("dbl_v_load",   32'(bus.o_v_count), GL ? 2 : 4);
    check("dbl_locked",   32'(bus.o_locked), 0);
    next_line();
    check("dbl_v_after",  32'(bus.o_v_count), GL ? 3 : 5);

    // Pulse on the line-step cycle: applied at the following line step
    wait_hv(13, 5);
    @(negedge clk_out);
    check("edge_pix_en", 32'(bus.o_pix_en), 1);
    pulse_frame_end();
    check("edge_h",      32'(bus.o_h_count), 0);
    check("edge_v_now",  32'(bus.o_v_count), 6);
    next_line();
    check("edge_v_next", 32'(bus.o_v_count), GL ? 2 : 0);
    check("edge_locked", 32'(bus.o_locked), 0);

    // Asynchronous reset mid-frame
    wait_hv(5, 3);
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk_out);
    reset = 1'b0;
    @(negedge clk_out);
    check("post_rst_pix_en1", 32'(bus.o_pix_en), 1);
    check("post_rst_hd_clk1", 32'(bus.o_hd_clk), 0);
    check("post_rst_h1",      32'(bus.o_h_count), 0);
    @(negedge clk_out);
    check("post_rst_pix_en2", 32'(bus.o_pix_en), 0);
    check("post_rst_hd_clk2", 32'(bus.o_hd_clk), 1);
    check("post_rst_h2",      32'(bus.o_h_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
